dm_port_arbiter: RTL and testbench

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter_if.sv | 42 ++++
 rtl/dm_port_arbiter.sv | 73 +++++++
 tb/tb_dm_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: CPU MEM-stage requester, DMA/debug requester
// and the shared single-port SRAM. The arbiter takes the slave view; the
// environment (CPU, DMA engine, SRAM) takes the master view.
interface dm_port_arbiter_if;
   // CPU requester
   logic        cpu_req;
   logic [3:0]  cpu_we;
   logic [13:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   // DMA/debug requester
   logic        dma_req;
   logic [3:0]  dma_we;
   logic [13:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_gnt;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   // SRAM port
   logic [3:0]  DM_write_en;
   logic [13:0] DM_addr;
   logic [31:0] DM_data_in;
   logic [31:0] data_from_mem;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output DM_write_en, DM_addr, DM_data_in,
      input  data_from_mem
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  DM_write_en, DM_addr, DM_data_in,
      output data_from_mem
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory SRAM port between the CPU MEM stage and a DMA/debug
// requester. The CPU has priority; a pending DMA request that keeps losing is
// forced through for one cycle once it has lost STARVE_LIMIT cycles in a row.
module dm_port_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   dm_port_arbiter_if.slave bus
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic [CW-1:0] r_starve_cnt;
   logic [CW-1:0] w_starve_next;
   logic [CW-1:0] w_cnt_eff;
   logic          r_rd_owner;
   logic          w_rd_owner_next;
   logic          w_dma_win;
   logic          w_rvalid;

   // Counter seen by the arbiter; forced to zero while reset is held so no forced grant can occur
   always_comb begin
      w_cnt_eff = rst ? '0 : r_starve_cnt;
   end

   // Ownership decision and SRAM port steering
   always_comb begin
      w_dma_win     = bus.dma_req && (!bus.cpu_req || (w_cnt_eff == LIMIT_C));
      bus.dma_gnt   = w_dma_win;
      bus.cpu_stall = bus.cpu_req && w_dma_win;
      if (w_dma_win) begin
         bus.DM_addr     = bus.dma_addr;
         bus.DM_write_en = bus.dma_we;
         bus.DM_data_in  = bus.dma_wdata;
      end else begin
         bus.DM_addr     = bus.cpu_addr;
         bus.DM_write_en = bus.cpu_req ? bus.cpu_we : 4'b1111;
         bus.DM_data_in  = bus.cpu_wdata;
      end
   end

   // Next starvation count and read-response ownership
   always_comb begin
      w_starve_next = w_cnt_eff;
      if (w_dma_win || !bus.dma_req) begin
         w_starve_next = '0;
      end else if (bus.cpu_req && (w_cnt_eff != LIMIT_C)) begin
         w_starve_next = w_cnt_eff + CW'(1);
      end
      w_rd_owner_next = w_dma_win && (bus.dma_we == 4'b1111);
   end

   // State registers, cleared synchronously
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
         r_rd_owner   <= 1'b0;
      end else begin
         r_starve_cnt <= w_starve_next;
         r_rd_owner   <= w_rd_owner_next;
      end
   end

   // DMA read return; suppressed while reset is held so a pending response is dropped
   always_comb begin
      w_rvalid       = r_rd_owner && !rst;
      bus.dma_rvalid = w_rvalid;
      bus.dma_rdata  = w_rvalid ? bus.data_from_mem : 32'd0;
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench for dm_port_arbiter with a cycle-level reference model
// and a behavioural SRAM; directed sequences cover the corner cases.
module tb_dm_port_arbiter;

   localparam int LIMIT = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dm_port_arbiter_if bus();

   dm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural single-port SRAM: byte writes (active-low), registered read of old data
   logic [31:0] mem [0:16383];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (!bus.DM_write_en[b]) mem[bus.DM_addr][8*b +: 8] <= bus.DM_data_in[8*b +: 8];
      end
      bus.data_from_mem <= mem[bus.DM_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int          m_lost      = 0;
   bit          m_pend_rd   = 0;
   logic [31:0] m_pend_data = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check against the model, advance the model
   task automatic cyc(input bit r, input bit cr, input logic [3:0] cw, input logic [13:0] ca,
                      input logic [31:0] cd, input bit dr, input logic [3:0] dw,
                      input logic [13:0] da, input logic [31:0] dd, output bit g);
      bit          e_gnt;
      bit          e_rv;
      int          lost_now;
      logic [3:0]  e_we;
      logic [13:0] e_addr;
      logic [31:0] e_data;
      @(negedge clk);
      rst = r;
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
      #1;
      lost_now = r ? 0 : m_lost;
      e_gnt  = dr && (!cr || lost_now == LIMIT);
      e_we   = e_gnt ? dw : (cr ? cw : 4'b1111);
      e_addr = e_gnt ? da : ca;
      e_data = e_gnt ? dd : cd;
      e_rv   = !r && m_pend_rd;
      check("gnt",    32'(bus.dma_gnt),     32'(e_gnt));
      check("stall",  32'(bus.cpu_stall),   32'(cr && e_gnt));
      check("we",     32'(bus.DM_write_en), 32'(e_we));
      check("addr",   32'(bus.DM_addr),     32'(e_addr));
      check("wdata",  bus.DM_data_in,       e_data);
      check("rvalid", 32'(bus.dma_rvalid),  32'(e_rv));
      check("rdata",  bus.dma_rdata,        e_rv ? m_pend_data : 32'd0);
      g = bus.dma_gnt;
      // advance model
      if (r || e_gnt || !dr) m_lost = 0;
      else if (cr)           m_lost = (lost_now < LIMIT) ? lost_now + 1 : LIMIT;
      m_pend_rd   = !r && e_gnt && (dw == 4'b1111);
      m_pend_data = mem[da];
      $display("[TB] cyc rst=%0d cpu=%0d dma=%0d gnt=%0d stall=%0d rv=%0d", r, cr, dr,
               bus.dma_gnt, bus.cpu_stall, bus.dma_rvalid);
   endtask

   bit          g;
   bit          dpend;
   logic [3:0]  dwe_h;
   logic [13:0] dad_h;
   logic [31:0] dwd_h;
   int          gpos;

   initial begin
      rst = 1'b1;
      bus.cpu_req = 0; bus.cpu_we = 4'hF; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 4'hF; bus.dma_addr = '0; bus.dma_wdata = '0;

      // Reset: no forced grant, no read response
      for (int i = 0; i < 3; i++) cyc(1, 1, 4'hF, 14'h5, 32'h1, 1, 4'hF, 14'h6, 32'h2, g);
      check("rst_rvalid", 32'(bus.dma_rvalid), 32'd0);

      // CPU byte write, no DMA
      cyc(0, 1, 4'b1110, 14'h010, 32'hA5, 0, 4'hF, 14'h0, 32'h0, g);
      check("cpu_wr_we",   32'(bus.DM_write_en), 32'(4'b1110));
      check("cpu_wr_addr", 32'(bus.DM_addr),     32'h010);

      // Preload 0x020 by DMA write, then DMA read returns it the next cycle
      cyc(0, 0, 4'hF, 14'h0, 32'h0, 1, 4'b0000, 14'h020, 32'hDEADBEEF, g);
      cyc(0, 0, 4'hF, 14'h0, 32'h0, 1, 4'hF, 14'h020, 32'h0, g);
      check("dma_rd_gnt", 32'(g), 32'd1);
      cyc(0, 0, 4'hF, 14'h0, 32'h0, 0, 4'hF, 14'h0, 32'h0, g);
      check("dma_rd_data", bus.dma_rdata, 32'hDEADBEEF);

      // Continuous contention: grant on every 9th cycle
      for (int i = 0; i < 2 * (LIMIT + 1); i++) begin
         cyc(0, 1, 4'hF, 14'h1, 32'h0, 1, 4'hF, 14'h2, 32'h0, g);
         check("starve_pat", 32'(g), 32'((i % (LIMIT + 1)) == LIMIT));
      end

      // Drop after 5 losses: counter restarts
      for (int i = 0; i < 5; i++) cyc(0, 1, 4'hF, 14'h1, 32'h0, 1, 4'hF, 14'h2, 32'h0, g);
      cyc(0, 1, 4'hF, 14'h1, 32'h0, 0, 4'hF, 14'h2, 32'h0, g);
      for (int i = 0; i <= LIMIT; i++) begin
         cyc(0, 1, 4'hF, 14'h1, 32'h0, 1, 4'hF, 14'h2, 32'h0, g);
         check("restart_pat", 32'(g), 32'(i == LIMIT));
      end

      // DMA full-word write to top address, no read response
      cyc(0, 0, 4'hF, 14'h0, 32'h0, 1, 4'b0000, 14'h3FFF, 32'h12345678, g);
      check("top_we",   32'(bus.DM_write_en), 32'(4'b0000));
      check("top_addr", 32'(bus.DM_addr),     32'h3FFF);
      cyc(0, 0, 4'hF, 14'h0, 32'h0, 0, 4'hF, 14'h0, 32'h0, g);
      check("top_no_rv", 32'(bus.dma_rvalid), 32'd0);

      // Reset right after a granted read drops the response
      cyc(0, 0, 4'hF, 14'h0, 32'h0, 1, 4'hF, 14'h020, 32'h0, g);
      cyc(1, 0, 4'hF, 14'h0, 32'h0, 0, 4'hF, 14'h0, 32'h0, g);
      check("rst_drop_rv", 32'(bus.dma_rvalid), 32'd0);
      check("rst_drop_rd", bus.dma_rdata,       32'd0);
      for (int i = 0; i <= LIMIT; i++) begin
         cyc(0, 1, 4'hF, 14'h1, 32'h0, 1, 4'hF, 14'h2, 32'h0, g);
         check("post_rst_pat", 32'(g), 32'(i == LIMIT));
      end

      // Randomized traffic; a DMA request is held stable until granted
      dpend = 0; dwe_h = 4'hF; dad_h = '0; dwd_h = '0; gpos = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!dpend && ($urandom_range(0, 2) != 0)) begin
            dpend = 1;
            dwe_h = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            dad_h = 14'($urandom_range(0, 63));
            dwd_h = $urandom;
         end
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 4'($urandom),
             14'($urandom_range(0, 63)), $urandom, dpend, dwe_h, dad_h, dwd_h, g);
         if (g) begin
            dpend = 0;
            gpos++;
         end
      end
      check("rand_some_gnt", 32'(gpos != 0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
